iter_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider that sits on the responder side of the ALU's divide-request stream interface.
- Accepts a dividend and a divisor on two independent valid/ready channels and returns a packed {quotient, remainder} word with a one-cycle valid pulse.
- The ALU instantiates one copy with SIGNED=1 (div/mod) and one with SIGNED=0 (divu/modu), so it never needs a vendor divider IP.

---
 rtl/iter_divider.sv | 130 +++++++++++++
 tb/tb_iter_divider.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Radix-2 restoring divider with independent dividend/divisor valid/ready channels.
// Produces {quotient, remainder} with a one-cycle valid pulse WIDTH cycles after both operands land.
module iter_divider #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    output logic                 m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]         state, state_n;
    logic               dvd_cap, dvd_cap_n, dvs_cap, dvs_cap_n;
    logic               rdy_dvd_q, rdy_dvd_n, rdy_dvs_q, rdy_dvs_n;
    logic               fire_dvd, fire_dvs, fin;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dvd_q, dvs_q, rem_q, quo_q;
    logic               dout_valid_q;
    logic [2*WIDTH-1:0] dout_q;

    assign s_axis_dividend_tready = rdy_dvd_q;
    assign s_axis_divisor_tready  = rdy_dvs_q;
    assign m_axis_dout_tvalid     = dout_valid_q;
    assign m_axis_dout_tdata      = dout_q;

    assign fire_dvd = s_axis_dividend_tvalid & rdy_dvd_q;
    assign fire_dvs = s_axis_divisor_tvalid  & rdy_dvs_q;

    // Magnitude datapath: operands stay latched for the whole CALC phase
    logic               dvd_neg, dvs_neg, dvd_bit, ge;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag, sub, rem_nxt, quo_nxt, q_fix, r_fix;
    logic [WIDTH:0]     shifted;
    logic [2*WIDTH-1:0] result;

    always_comb begin
        dvd_neg = SIGNED & dvd_q[WIDTH-1];
        dvs_neg = SIGNED & dvs_q[WIDTH-1];
        dvd_mag = dvd_neg ? (~dvd_q + WIDTH'(1)) : dvd_q;
        dvs_mag = dvs_neg ? (~dvs_q + WIDTH'(1)) : dvs_q;
        dvd_bit = dvd_mag[CNT_W'(WIDTH-1) - cnt];
        shifted = {rem_q, dvd_bit};
        ge      = shifted >= {1'b0, dvs_mag};
        // When ge holds the true difference is below 2^WIDTH, so modular low bits are exact
        sub     = shifted[WIDTH-1:0] - dvs_mag;
        rem_nxt = ge ? sub : shifted[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], ge};
        q_fix   = (dvd_neg ^ dvs_neg) ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
        r_fix   = dvd_neg ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
        result  = (dvs_q == '0) ? {{WIDTH{1'b1}}, dvd_q} : {q_fix, r_fix};
    end

    // Next-state and handshake control
    always_comb begin
        state_n   = state;
        dvd_cap_n = dvd_cap;
        dvs_cap_n = dvs_cap;
        fin       = 1'b0;
        case (state)
            S_IDLE: begin
                dvd_cap_n = dvd_cap | fire_dvd;
                dvs_cap_n = dvs_cap | fire_dvs;
                if (dvd_cap_n && dvs_cap_n) begin
                    state_n   = S_CALC;
                    dvd_cap_n = 1'b0;
                    dvs_cap_n = 1'b0;
                end
            end
            S_CALC: begin
                if (cnt == CNT_W'(WIDTH-1)) begin
                    state_n = S_OUT;
                    fin     = 1'b1;
                end
            end
            S_OUT:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        rdy_dvd_n = (state_n == S_IDLE) & ~dvd_cap_n;
        rdy_dvs_n = (state_n == S_IDLE) & ~dvs_cap_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            dvd_cap      <= 1'b0;
            dvs_cap      <= 1'b0;
            rdy_dvd_q    <= 1'b0;
            rdy_dvs_q    <= 1'b0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            cnt          <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state        <= state_n;
            dvd_cap      <= dvd_cap_n;
            dvs_cap      <= dvs_cap_n;
            rdy_dvd_q    <= rdy_dvd_n;
            rdy_dvs_q    <= rdy_dvs_n;
            dout_valid_q <= fin;
            if (fire_dvd) dvd_q <= s_axis_dividend_tdata;
            if (fire_dvs) dvs_q <= s_axis_divisor_tdata;
            if (state == S_CALC) begin
                cnt   <= cnt + CNT_W'(1);
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
            end else begin
                cnt   <= '0;
                rem_q <= '0;
                quo_q <= '0;
            end
            if (fin) dout_q <= result;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: signed and unsigned copies share one stimulus stream,
// results are matched against per-copy expectation queues.
module tb_iter_divider;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic           dvd_valid, dvs_valid;
    logic [W-1:0]   dvd_data, dvs_data;
    logic           dvd_rdy_s, dvs_rdy_s, vld_s;
    logic           dvd_rdy_u, dvs_rdy_u, vld_u;
    logic [2*W-1:0] dat_s, dat_u;

    iter_divider #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy_s),
        .s_axis_dividend_tdata(dvd_data),
        .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy_s),
        .s_axis_divisor_tdata(dvs_data),
        .m_axis_dout_tvalid(vld_s), .m_axis_dout_tdata(dat_s)
    );

    iter_divider #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy_u),
        .s_axis_dividend_tdata(dvd_data),
        .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy_u),
        .s_axis_divisor_tdata(dvs_data),
        .m_axis_dout_tvalid(vld_u), .m_axis_dout_tdata(dat_u)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    logic [63:0] exp_s_q[$];
    logic [63:0] exp_u_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Scoreboard: every valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (vld_s) begin
            chk("sb_pending_s", 64'(exp_s_q.size() != 0), 64'd1);
            if (exp_s_q.size() != 0) chk("dout_s", dat_s, exp_s_q.pop_front());
        end
        if (vld_u) begin
            chk("sb_pending_u", 64'(exp_u_q.size() != 0), 64'd1);
            if (exp_u_q.size() != 0) chk("dout_u", dat_u, exp_u_q.pop_front());
        end
    end

    task automatic wait_pulse(output int unsigned pc, output bit seen);
        seen = 1'b0;
        pc   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (vld_s) begin
                seen = 1'b1;
                pc   = cyc;
            end
        end
    endtask

    // Called 1 time unit after a rising edge with both readies high
    task automatic offer(input logic [31:0] a, input logic [31:0] b, input int gap,
                         input logic [63:0] es, input logic [63:0] eu);
        int unsigned e0, pc;
        bit seen;
        exp_s_q.push_back(es);
        exp_u_q.push_back(eu);
        dvd_data  = a;
        dvd_valid = 1'b1;
        if (gap == 0) begin
            dvs_data  = b;
            dvs_valid = 1'b1;
        end
        @(posedge clk); #1;
        dvd_valid = 1'b0;
        if (gap > 0) begin
            chk("dvd_rdy_after_capture", 64'(dvd_rdy_s), 64'd0);
            chk("dvs_rdy_still_open", 64'(dvs_rdy_s), 64'd1);
            repeat (gap - 1) @(posedge clk);
            #1;
            dvs_data  = b;
            dvs_valid = 1'b1;
            @(posedge clk); #1;
        end
        dvs_valid = 1'b0;
        e0 = cyc;
        chk("rdy_low_calc", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'd0);
        wait_pulse(pc, seen);
        chk("pulse_seen", 64'(seen), 64'd1);
        if (seen) chk("latency", 64'(pc - e0), 64'd32);
        @(posedge clk); #1;
        chk("pulse_one_cycle", 64'({vld_s, vld_u}), 64'd0);
        chk("rdy_after_pulse", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e0, p1, p2, pc, npulse;
        bit seen1, seen2;
        logic [31:0] ra, rb;

        resetn    = 1'b0;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        dvd_data  = '0;
        dvs_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'd0);
        chk("reset_valid", 64'({vld_s, vld_u}), 64'd0);
        chk("reset_data_s", dat_s, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_reset", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'hF);

        offer(32'd100, 32'd7, 0, 64'h0000000E_00000002, 64'h0000000E_00000002);
        offer(32'hFFFFFFF9, 32'h00000002, 0, 64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001);
        offer(32'h00000007, 32'hFFFFFFFE, 0, 64'hFFFFFFFD_00000001, 64'h00000000_00000007);
        offer(32'hFFFFFFF9, 32'hFFFFFFFE, 0, 64'h00000003_FFFFFFFF, 64'h00000000_FFFFFFF9);
        offer(32'h12345678, 32'h00000010, 3, 64'h01234567_00000008, 64'h01234567_00000008);
        offer(32'h0000002A, 32'h00000000, 0, 64'hFFFFFFFF_0000002A, 64'hFFFFFFFF_0000002A);
        offer(32'hFFFFFFF9, 32'h00000000, 0, 64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_FFFFFFF9);
        offer(32'h80000000, 32'hFFFFFFFF, 0, 64'h80000000_00000000, 64'h00000000_80000000);

        // Abort a division ten cycles into CALC
        dvd_data  = 32'd500;
        dvs_data  = 32'd9;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        @(posedge clk); #1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("abort_valid", 64'({vld_s, vld_u}), 64'd0);
        chk("abort_data_s", dat_s, 64'd0);
        chk("abort_data_u", dat_u, 64'd0);
        chk("abort_rdy", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("abort_rdy_release", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'hF);
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (vld_s || vld_u) npulse++;
        end
        chk("abort_no_pulse", 64'(npulse), 64'd0);

        // Back-to-back with operands held valid
        dvd_data  = 32'd1000;
        dvs_data  = 32'd3;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        exp_s_q.push_back(model(1'b1, 32'd1000, 32'd3));
        exp_u_q.push_back(model(1'b0, 32'd1000, 32'd3));
        @(posedge clk); #1;
        e0 = cyc;
        dvd_data = 32'hFFFFFF9C;
        dvs_data = 32'd7;
        exp_s_q.push_back(model(1'b1, 32'hFFFFFF9C, 32'd7));
        exp_u_q.push_back(model(1'b0, 32'hFFFFFF9C, 32'd7));
        wait_pulse(p1, seen1);
        wait_pulse(p2, seen2);
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        chk("b2b_seen", 64'({seen1, seen2}), 64'd3);
        chk("b2b_first_latency", 64'(p1 - e0), 64'd32);
        chk("b2b_spacing", 64'(p2 - p1), 64'd34);
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (k == 4) rb = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            offer(ra, rb, k % 3, model(1'b1, ra, rb), model(1'b0, ra, rb));
        end

        pc = exp_s_q.size() + exp_u_q.size();
        chk("sb_drained", 64'(pc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
